// File: rtl/encoder_8to3_queued_if.sv
// encoder_8to3_queued_if: capture strobes, pending status and the valid/ready event channel
interface encoder_8to3_queued_if #(
  parameter int N = 8,
  parameter int W = 3
);
  logic         E;
  logic [N-1:0] D;
  logic [W-1:0] Q;
  logic         valid;
  logic         ready;
  logic [N-1:0] pend;
  logic         lost;
  modport master (output E, D, ready, input Q, valid, pend, lost);
  modport slave  (input E, D, ready, output Q, valid, pend, lost);
endinterface

// File: rtl/encoder_8to3_queued.sv
// encoder_8to3_queued: latches request strobes and hands them out as priority-ordered indices
module encoder_8to3_queued #(
  parameter int N        = 8,
  parameter int W        = 3,
  parameter int HIGH_PRI = 0
) (
  input logic                 clk,
  input logic                 rst,
  encoder_8to3_queued_if.slave enc_if
);
  typedef enum logic {IDLE, HOLD} state_e;
  state_e       state_q, state_d;
  logic [N-1:0] pend_q, pend_d, set, clr;
  logic [W-1:0] q_q, q_d, win;
  logic         valid_q, valid_d, lost_q, lost_d, load;
  always_comb begin
    win = '0;
    for (int i = 0; i < N; i++)
      if (HIGH_PRI != 0 ? pend_q[i] : pend_q[N-1-i]) win = HIGH_PRI != 0 ? W'(i) : W'(N-1-i);
  end
  assign set = enc_if.E ? enc_if.D : '0;
  // a completed transfer reloads only if something is pending that is not being re-strobed
  assign load = state_q == IDLE ? |pend_q : enc_if.ready && |(pend_q & ~set);
  assign clr = load ? N'(1) << win : '0;
  always_comb begin
    state_d = load ? HOLD : (state_q == HOLD && enc_if.ready) ? IDLE : state_q;
    valid_d = load || (valid_q && !enc_if.ready);
    q_d     = load ? win : q_q;
    pend_d  = (pend_q & ~clr) | set;
    lost_d  = |(set & pend_q & ~clr);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      lost_q  <= lost_d;
    end
  end
  assign enc_if.Q     = q_q;
  assign enc_if.valid = valid_q;
  assign enc_if.pend  = pend_q;
  assign enc_if.lost  = lost_q;
endmodule

// File: tb/tb_encoder_8to3_queued.sv
// tb_encoder_8to3_queued: drives both priority variants and scoreboards every transfer
module tb_encoder_8to3_queued;
  logic       clk = 1'b0, rst = 1'b1, e = 1'b0, ready = 1'b0;
  logic [7:0] d = 8'h00;
  always #5 clk = ~clk;
  encoder_8to3_queued_if #(.N(8), .W(3)) if0 (), if1 ();
  assign if0.E = e;
  assign if0.D = d;
  assign if0.ready = ready;
  assign if1.E = e;
  assign if1.D = d;
  assign if1.ready = ready;
  encoder_8to3_queued #(.N(8), .W(3), .HIGH_PRI(0)) dut0 (.clk(clk), .rst(rst), .enc_if(if0));
  encoder_8to3_queued #(.N(8), .W(3), .HIGH_PRI(1)) dut1 (.clk(clk), .rst(rst), .enc_if(if1));
  logic [2:0] dq [2];
  logic [7:0] dp [2];
  logic       dv [2], dl [2];
  assign dq[0] = if0.Q;
  assign dq[1] = if1.Q;
  assign dp[0] = if0.pend;
  assign dp[1] = if1.pend;
  assign dv[0] = if0.valid;
  assign dv[1] = if1.valid;
  assign dl[0] = if0.lost;
  assign dl[1] = if1.lost;
  // reference state: a set of pending line numbers plus the event currently on offer
  bit m_pend [2][8];
  bit m_valid [2], m_lost [2];
  int m_q [2];
  int exp0 [$], exp1 [$];
  int tests = 0, fails = 0, mon_x;
  bit armed = 1'b0;
  task automatic chk(string n, int p, int a, int x);
    tests++;
    if (a != x) begin
      fails++;
      $display("FAIL %s[pri%0d]: got %0h expected %0h", n, p, a, x);
    end
  endtask
  function automatic int pend_word(int p);
    int w = 0;
    for (int i = 0; i < 8; i++) if (m_pend[p][i]) w += 1 << i;
    return w;
  endfunction
  function automatic void mreset();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 8; i++) m_pend[p][i] = 1'b0;
      m_valid[p] = 1'b0;
      m_lost[p] = 1'b0;
      m_q[p] = 0;
    end
  endfunction
  function automatic void step(int p, bit en, logic [7:0] dd, bit rdy);
    bit s [8];
    bit any_p = 1'b0, any_rem = 1'b0, done;
    int k = -1;
    for (int i = 0; i < 8; i++) begin
      s[i] = en && dd[i];
      any_p |= m_pend[p][i];
      any_rem |= m_pend[p][i] && !s[i];
    end
    done = m_valid[p] && rdy;
    if (!m_valid[p] ? any_p : (done && any_rem))
      for (int i = 0; i < 8; i++) begin
        int j = p == 0 ? 7 - i : i;
        if (m_pend[p][j]) k = j;
      end
    m_lost[p] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (s[i] && m_pend[p][i] && i != k) m_lost[p] = 1'b1;
      m_pend[p][i] = (m_pend[p][i] && i != k) || s[i];
    end
    if (k >= 0) begin
      m_q[p] = k;
      m_valid[p] = 1'b1;
    end else if (done) m_valid[p] = 1'b0;
  endfunction
  task automatic cyc(bit r, bit en, logic [7:0] dd, bit rdy);
    rst = r;
    e = en;
    d = dd;
    ready = rdy;
    if (!r && rdy && m_valid[0]) exp0.push_back(m_q[0]);
    if (!r && rdy && m_valid[1]) exp1.push_back(m_q[1]);
    @(posedge clk);
    #2;
    if (r) mreset();
    else for (int p = 0; p < 2; p++) step(p, en, dd, rdy);
  endtask
  always @(negedge clk) if (armed) begin
    for (int p = 0; p < 2; p++) begin
      chk("valid", p, int'(dv[p]), int'(m_valid[p]));
      chk("q", p, int'(dq[p]), m_q[p]);
      chk("pend", p, int'(dp[p]), pend_word(p));
      chk("lost", p, int'(dl[p]), int'(m_lost[p]));
      if (dv[p] && ready && !rst) begin
        if ((p == 0 ? exp0.size() : exp1.size()) == 0) begin
          tests++;
          fails++;
          $display("FAIL xfer_unexpected[pri%0d]: got transfer q=%0d expected none", p, dq[p]);
        end else begin
          mon_x = p == 0 ? exp0.pop_front() : exp1.pop_front();
          chk("xfer", p, int'(dq[p]), mon_x);
        end
      end
    end
  end
  initial begin
    @(posedge clk);
    #2;
    mreset();
    armed = 1'b1;
    cyc(0, 1, 8'h20, 1);
    repeat (4) cyc(0, 0, 8'h00, 1);
    cyc(0, 1, 8'hA5, 1);
    repeat (6) cyc(0, 0, 8'h00, 1);
    cyc(0, 1, 8'h03, 0);
    repeat (5) cyc(0, 0, 8'h00, 0);
    repeat (4) cyc(0, 0, 8'h00, 1);
    cyc(0, 1, 8'h09, 0);
    cyc(0, 0, 8'h00, 0);
    cyc(0, 1, 8'h08, 0);
    repeat (5) cyc(0, 0, 8'h00, 1);
    repeat (3) cyc(0, 0, 8'hFF, 1);
    cyc(0, 1, 8'h10, 0);
    repeat (2) cyc(0, 0, 8'hFF, 0);
    repeat (3) cyc(0, 0, 8'hFF, 1);
    cyc(0, 1, 8'h0D, 0);
    cyc(0, 0, 8'h00, 0);
    cyc(1, 1, 8'hFF, 1);
    repeat (4) cyc(0, 0, 8'h00, 1);
    repeat (400)
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
          8'($urandom_range(0, 255) & $urandom_range(0, 255)), $urandom_range(0, 2) != 0);
    repeat (12) cyc(0, 0, 8'h00, 1);
    @(negedge clk);
    #1;
    chk("queue_left", 0, exp0.size(), 0);
    chk("queue_left", 1, exp1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
